led_matrix_scanner: RTL and testbench

- Downstream display stage for the 8x8 Life board.
- Accepts 64-bit generation snapshots through a valid/ready handshake and double-buffers them, so the display only changes at a frame boundary (no tearing).
- Time-multiplexes the buffer onto the LED matrix: one column active at a time, row data active-low, with a blanking gap between columns to suppress ghosting.
- Replaces the ad-hoc tick-indexed row muxing in the top level.

---
 rtl/led_scan_pkg.sv | 12 +
 rtl/led_matrix_scanner_decoder3_8.sv | 16 +
 rtl/led_matrix_scanner.sv | 169 ++++++++++++++++
 tb/tb_led_matrix_scanner.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and sizes for the 8x8 LED matrix scanner.
package led_scan_pkg;

    localparam int N_COLS  = 8;
    localparam int N_ROWS  = 8;
    localparam int N_CELLS = 64;

    typedef enum logic {S_BLANK, S_DRIVE} scan_state_t;

    typedef logic [N_CELLS-1:0] frame_t;

endpackage

// File: rtl/led_matrix_scanner_decoder3_8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder3_8
    import led_scan_pkg::*;
(
    input  logic [2:0]        sel,
    input  logic              en,
    output logic [N_COLS-1:0] dec
);

    generate
        for (genvar gi = 0; gi < N_COLS; gi++) begin : g_dec
            assign dec[gi] = en && (sel == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered column-multiplexed driver for the 8x8 Life display.
// Optional brightness PWM on the row drive is enabled with LED_SCAN_PWM_EN.
module led_matrix_scanner
    import led_scan_pkg::*;
#(
    parameter int DWELL_CYCLES = 1500,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CELLS-1:0] frame_in,
    input  logic               frame_valid,
`ifdef LED_SCAN_PWM_EN
    input  logic [2:0]         brightness,
`endif
    output logic               frame_ready,
    output logic               frame_start,
    output logic [N_ROWS-1:0]  rows_out,
    output logic [N_COLS-1:0]  columns_out
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                             ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                             ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam scan_state_t INIT_STATE = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;

    scan_state_t       state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        col_reg, col_next;
    logic              armed_reg;
    logic              boundary;

    frame_t            display_reg, display_next;
    frame_t            pending_reg;
    logic              pending_full_reg, pending_full_next;
    logic              transfer;
    logic              swap;

    logic [N_ROWS-1:0] rows_reg, rows_next;
    logic [N_COLS-1:0] columns_reg, columns_next;
    logic              start_reg;
    logic              drive_next;
    logic              on_time;
    logic [N_ROWS-1:0] col_rows [N_COLS];
    logic [N_ROWS-1:0] row_data;

    // The first cycle after reset release is a frame boundary that does not
    // advance the scan, so blank/drive timing starts cleanly from column 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        col_next   = col_reg;
        boundary   = 1'b0;
        if (!armed_reg) begin
            boundary = 1'b1;
        end else begin
            case (state_reg)
                S_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = S_DRIVE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt_reg == DWELL_LAST) begin
                        cnt_next   = '0;
                        col_next   = col_reg + 3'd1;
                        state_next = INIT_STATE;
                        boundary   = (col_reg == 3'd7);
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                default: state_next = INIT_STATE;
            endcase
        end
    end

    // A transfer and a swap can never coincide: a swap needs pending_full,
    // which holds frame_ready low.
    always_comb begin
        transfer          = frame_valid && !pending_full_reg;
        swap              = boundary && pending_full_reg;
        display_next      = swap ? pending_reg : display_reg;
        pending_full_next = pending_full_reg;
        if (transfer) begin
            pending_full_next = 1'b1;
        end else if (swap) begin
            pending_full_next = 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_COLS; gi++) begin : g_col_rows
            assign col_rows[gi] = display_next[gi*N_ROWS +: N_ROWS];
        end
    endgenerate

    assign row_data   = col_rows[col_next];
    assign drive_next = (state_next == S_DRIVE);

`ifdef LED_SCAN_PWM_EN
    logic [2:0]  bright_reg, bright_next;
    logic [31:0] pwm_limit;

    always_comb begin
        bright_next = boundary ? brightness : bright_reg;
        pwm_limit   = (({29'd0, bright_next} + 32'd1) * 32'(DWELL_CYCLES)) >> 3;
        on_time     = (32'(cnt_next) < pwm_limit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bright_reg <= 3'd7;
        end else begin
            bright_reg <= bright_next;
        end
    end
`else
    assign on_time = 1'b1;
`endif

    decoder3_8 u_col_dec (
        .sel (col_next),
        .en  (drive_next),
        .dec (columns_next)
    );

    assign rows_next = (drive_next && on_time) ? ~row_data : {N_ROWS{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= INIT_STATE;
            cnt_reg          <= '0;
            col_reg          <= '0;
            armed_reg        <= 1'b0;
            display_reg      <= '0;
            pending_reg      <= '0;
            pending_full_reg <= 1'b0;
            rows_reg         <= {N_ROWS{1'b1}};
            columns_reg      <= '0;
            start_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            cnt_reg          <= cnt_next;
            col_reg          <= col_next;
            armed_reg        <= 1'b1;
            display_reg      <= display_next;
            pending_full_reg <= pending_full_next;
            rows_reg         <= rows_next;
            columns_reg      <= columns_next;
            start_reg        <= boundary;
            if (transfer) begin
                pending_reg <= frame_in;
            end
        end
    end

    assign frame_ready = ~pending_full_reg;
    assign frame_start = start_reg;
    assign rows_out    = rows_reg;
    assign columns_out = columns_reg;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with DWELL_CYCLES=4, BLANK_CYCLES=2 (48-cycle frame).
module tb_led_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] frame_in = '0;
    logic        frame_valid = 1'b0;
    logic        frame_ready;
    logic        frame_start;
    logic [7:0]  rows_out;
    logic [7:0]  columns_out;
`ifdef LED_SCAN_PWM_EN
    logic [2:0]  brightness = 3'd7;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int p     = 0;

    localparam logic [63:0] PAT   = 64'h0102040810204080;
    localparam logic [63:0] FR_A  = 64'h00000000000000AA;
    localparam logic [63:0] FR_B  = 64'h0000000000000055;
    localparam logic [63:0] FR_C  = 64'h00000000000000F0;
    localparam logic [63:0] FR_D  = 64'h00000000000000C3;

    logic [7:0] scan_rows [8] = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
    logic [7:0] scan_cols [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    always #5 clk = ~clk;

    led_matrix_scanner #(
        .DWELL_CYCLES (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
`ifdef LED_SCAN_PWM_EN
        .brightness  (brightness),
`endif
        .frame_ready (frame_ready),
        .frame_start (frame_start),
        .rows_out    (rows_out),
        .columns_out (columns_out)
    );

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            $display("vec %0d %s ok (%h)", n_vec, tag, obs);
        end
    endtask

    // Advance to frame position 'target' (cycles since the frame_start cycle), sampling on negedge.
    task automatic goto(input int target);
        repeat (target - p) @(negedge clk);
        p = target;
    endtask

    task automatic next_frame();
        goto(47);
        check_vec("pre_start", 64'(frame_start), 64'd0);
        goto(48);
        check_vec("frame_start", 64'(frame_start), 64'd1);
        p = 0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_vec("rst_rows", 64'(rows_out), 64'hFF);
        check_vec("rst_cols", 64'(columns_out), 64'h00);
        check_vec("rst_ready", 64'(frame_ready), 64'd1);
        check_vec("rst_start", 64'(frame_start), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        p = 0;
        check_vec("first_start", 64'(frame_start), 64'd1);
        check_vec("first_cols", 64'(columns_out), 64'h00);
        goto(1);
        check_vec("blank1_cols", 64'(columns_out), 64'h00);
        goto(2);
        check_vec("col0_cols", 64'(columns_out), 64'h01);
        check_vec("col0_rows", 64'(rows_out), 64'hFF);

        // Tear-free: push all-ones while column 3 shows the blank frame
        goto(20);
        check_vec("tear_col3", 64'(columns_out), 64'h08);
        frame_valid = 1'b1;
        frame_in    = '1;
        goto(21);
        check_vec("tear_ready", 64'(frame_ready), 64'd0);
        frame_valid = 1'b0;
        for (int c = 4; c < 8; c++) begin
            goto(6*c + 2);
            check_vec("tear_cols", 64'(columns_out), 64'(scan_cols[c]));
            check_vec("tear_rows", 64'(rows_out), 64'hFF);
        end
        next_frame();
        check_vec("swap_ready", 64'(frame_ready), 64'd1);
        goto(2);
        check_vec("ones_col0", 64'(rows_out), 64'h00);

        // Scan order with a diagonal pattern
        goto(44);
        check_vec("ones_col7", 64'(rows_out), 64'h00);
        frame_valid = 1'b1;
        frame_in    = PAT;
        goto(45);
        frame_valid = 1'b0;
        next_frame();
        for (int c = 0; c < 8; c++) begin
            goto(6*c + 1);
            check_vec("scan_blank", 64'(columns_out), 64'h00);
            check_vec("scan_blank_rows", 64'(rows_out), 64'hFF);
            goto(6*c + 2);
            check_vec("scan_cols_a", 64'(columns_out), 64'(scan_cols[c]));
            check_vec("scan_rows_a", 64'(rows_out), 64'(scan_rows[c]));
            goto(6*c + 5);
            check_vec("scan_cols_b", 64'(columns_out), 64'(scan_cols[c]));
            check_vec("scan_rows_b", 64'(rows_out), 64'(scan_rows[c]));
        end
        next_frame();

        // Backpressure: A accepted, B held until after the swap
        frame_valid = 1'b1;
        frame_in    = FR_A;
        goto(1);
        check_vec("bp_ready_a", 64'(frame_ready), 64'd0);
        frame_in = FR_B;
        goto(10);
        check_vec("bp_ready_mid", 64'(frame_ready), 64'd0);
        goto(47);
        check_vec("bp_ready_end", 64'(frame_ready), 64'd0);
        next_frame();
        check_vec("bp_ready_swap", 64'(frame_ready), 64'd1);
        goto(1);
        check_vec("bp_ready_b", 64'(frame_ready), 64'd0);
        frame_valid = 1'b0;
        goto(2);
        check_vec("bp_show_a", 64'(rows_out), 64'h55);
        next_frame();
        goto(2);
        check_vec("bp_show_b", 64'(rows_out), 64'hAA);

        // Transfer on the exact swap edge
        goto(47);
        check_vec("sim_ready_pre", 64'(frame_ready), 64'd1);
        frame_valid = 1'b1;
        frame_in    = FR_C;
        next_frame();
        check_vec("sim_ready_post", 64'(frame_ready), 64'd0);
        frame_valid = 1'b0;
        goto(2);
        check_vec("sim_still_b", 64'(rows_out), 64'hAA);
        next_frame();
        check_vec("sim_ready_swap", 64'(frame_ready), 64'd1);
        goto(2);
        check_vec("sim_show_c", 64'(rows_out), 64'h0F);

        // Asynchronous reset mid-drive with a frame pending
        goto(8);
        frame_valid = 1'b1;
        frame_in    = FR_D;
        goto(9);
        check_vec("mid_ready_pre", 64'(frame_ready), 64'd0);
        frame_valid = 1'b0;
        goto(10);
        check_vec("mid_cols_pre", 64'(columns_out), 64'h02);
        rst = 1'b1;
        #1;
        check_vec("mid_rst_rows", 64'(rows_out), 64'hFF);
        check_vec("mid_rst_cols", 64'(columns_out), 64'h00);
        check_vec("mid_rst_ready", 64'(frame_ready), 64'd1);
        check_vec("mid_rst_start", 64'(frame_start), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        p = 0;
        check_vec("mid_first_start", 64'(frame_start), 64'd1);
        goto(2);
        check_vec("mid_col0_cols", 64'(columns_out), 64'h01);
        check_vec("mid_col0_rows", 64'(rows_out), 64'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
